// File: rtl/packager_pkg.sv
// Shared state encoding and sizing helpers for frame_packager and its FIFO.
package packager_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2,
      FLUSH   = 2'd3
   } state_t;

   // FIFO entries carry {tuser, tlast, tdata}
   localparam int unsigned SIDEBAND_W = 2;

   function automatic int unsigned entry_w(input int unsigned data_w);
      return data_w + SIDEBAND_W;
   endfunction

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/packager_fifo.sv
// Synchronous FIFO with a registered output stage; an empty FIFO forwards a push straight
// into the output register so data appears one cycle after it is written.
module packager_fifo
   import packager_pkg::*;
#(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 16
) (
   input  logic             video_clk,
   input  logic             video_reset,
   input  logic             soft_reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             full,
   output logic             full_nxt_c
);

   localparam int unsigned PTR_W = clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             load_out;
   logic             mem_rd;
   logic             mem_wr;
   logic             bypass;

   // Output register reloads whenever it is empty or being consumed
   always_comb begin
      load_out = !out_valid || pop_ready;
      mem_rd   = load_out && (cnt != '0);
      bypass   = load_out && (cnt == '0) && push;
      mem_wr   = push && !bypass;
      cnt_nxt  = cnt;
      if (mem_wr && !mem_rd) begin
         cnt_nxt = cnt + CNT_W'(1);
      end else if (!mem_wr && mem_rd) begin
         cnt_nxt = cnt - CNT_W'(1);
      end
   end

   assign full_nxt_c = (cnt_nxt == CNT_W'(DEPTH));

   always_ff @(posedge video_clk) begin
      if (mem_wr) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge video_clk or posedge video_reset) begin
      if (video_reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         full      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (soft_reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         full      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (mem_wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (mem_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         cnt  <= cnt_nxt;
         full <= full_nxt_c;
         if (load_out) begin
            if (mem_rd) begin
               out_valid <= 1'b1;
               out_data  <= mem[rd_ptr];
            end else if (bypass) begin
               out_valid <= 1'b1;
               out_data  <= push_data;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/frame_packager.sv
// Packs line_count video lines after start-of-frame into one AXI-Stream packet for a DMA.
// Define PACKAGER_STATS_EN to implement frame_count and sof_err_count.
module frame_packager
   import packager_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned LCNT_W     = 16,
   parameter int unsigned CONTINUOUS = 1
) (
   input  logic              video_clk,
   input  logic              video_reset,
   input  logic              enable,
   input  logic              soft_reset,
   input  logic [LCNT_W-1:0] line_count,
   output logic [LCNT_W-1:0] lines_done,
   output logic              busy,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tuser,
   input  logic              s_axis_tlast,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser,
   output logic [31:0]       frame_count,
   output logic [15:0]       sof_err_count
);

   localparam int unsigned ENTRY_W = entry_w(DATA_W);
   localparam int unsigned LNUM_W  = LCNT_W + 1;

   typedef struct packed {
      logic              user;
      logic              last;
      logic [DATA_W-1:0] data;
   } beat_t;

   state_t            state_q;
   state_t            state_nxt;
   logic [LCNT_W-1:0] lcnt_q;
   logic [LCNT_W-1:0] lcnt_nxt;
   logic [LCNT_W-1:0] lines_nxt;
   logic [LCNT_W-1:0] cnt_eff;
   logic              stop_q;
   logic              stop_nxt;
   logic              stop_now;
   logic              enable_q;
   logic              arm_req;
   logic              accept;
   logic              push;
   logic              pkt_end;
   logic              pop_last;
   logic              tready_nxt;
   logic              busy_nxt;
   logic              fifo_full;
   logic              fifo_full_nxt;
   logic [ENTRY_W-1:0] out_data;
   beat_t             push_beat;
   beat_t             out_beat;

   assign accept   = s_axis_tvalid && s_axis_tready;
   assign cnt_eff  = (line_count == '0) ? LCNT_W'(1) : line_count;
   assign arm_req  = (CONTINUOUS != 0) ? enable : (enable && !enable_q);
   assign pop_last = m_axis_tvalid && m_axis_tready && m_axis_tlast;

   // Next state, line counting and FIFO write decision
   always_comb begin
      state_nxt = state_q;
      lcnt_nxt  = lcnt_q;
      lines_nxt = lines_done;
      stop_nxt  = stop_q;
      stop_now  = 1'b0;
      push      = 1'b0;
      pkt_end   = 1'b0;
      push_beat = '{user: 1'b0, last: 1'b0, data: s_axis_tdata};
      case (state_q)
         IDLE: begin
            if (arm_req) begin
               state_nxt = ARM;
            end
         end
         ARM: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (accept && s_axis_tuser) begin
               state_nxt      = CAPTURE;
               lcnt_nxt       = cnt_eff;
               lines_nxt      = '0;
               stop_nxt       = 1'b0;
               push           = 1'b1;
               push_beat.user = 1'b1;
               if (s_axis_tlast) begin
                  lines_nxt = LCNT_W'(1);
                  pkt_end   = (cnt_eff == LCNT_W'(1));
               end
            end
         end
         CAPTURE: begin
            stop_now = stop_q || !enable;
            stop_nxt = stop_now;
            if (accept) begin
               push = 1'b1;
               if (s_axis_tlast) begin
                  if (lines_done != '1) begin
                     lines_nxt = lines_done + LCNT_W'(1);
                  end
                  // a dropped enable truncates the packet at this line end
                  pkt_end = stop_now ||
                            ((LNUM_W'(lines_done) + LNUM_W'(1)) == LNUM_W'(lcnt_q));
               end
            end
         end
         FLUSH: begin
            if (pop_last) begin
               state_nxt = (enable && (CONTINUOUS != 0)) ? ARM : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (pkt_end) begin
         push_beat.last = 1'b1;
         state_nxt      = FLUSH;
      end
   end

   // Registered source-side ready and busy, derived from the next state
   always_comb begin
      tready_nxt = 1'b0;
      case (state_nxt)
         IDLE, ARM: tready_nxt = 1'b1;
         CAPTURE:   tready_nxt = !fifo_full_nxt;
         default:   tready_nxt = 1'b0;
      endcase
      busy_nxt = (state_nxt == CAPTURE) || (state_nxt == FLUSH);
   end

   always_ff @(posedge video_clk or posedge video_reset) begin
      if (video_reset) begin
         state_q       <= IDLE;
         lcnt_q        <= '0;
         lines_done    <= '0;
         stop_q        <= 1'b0;
         enable_q      <= 1'b0;
         s_axis_tready <= 1'b0;
         busy          <= 1'b0;
      end else if (soft_reset) begin
         state_q       <= IDLE;
         lcnt_q        <= '0;
         lines_done    <= '0;
         stop_q        <= 1'b0;
         enable_q      <= enable;
         s_axis_tready <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_nxt;
         lcnt_q        <= lcnt_nxt;
         lines_done    <= lines_nxt;
         stop_q        <= stop_nxt;
         enable_q      <= enable;
         s_axis_tready <= tready_nxt;
         busy          <= busy_nxt;
      end
   end

   packager_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .video_clk   (video_clk),
      .video_reset (video_reset),
      .soft_reset  (soft_reset),
      .push        (push),
      .push_data   (push_beat),
      .pop_ready   (m_axis_tready),
      .out_valid   (m_axis_tvalid),
      .out_data    (out_data),
      .full        (fifo_full),
      .full_nxt_c  (fifo_full_nxt)
   );

   assign out_beat     = out_data;
   assign m_axis_tdata = out_beat.data;
   assign m_axis_tlast = out_beat.last;
   assign m_axis_tuser = out_beat.user;

`ifdef PACKAGER_STATS_EN
   logic [31:0] frame_q;
   logic [15:0] sof_err_q;

   // frame_count wraps, sof_err_count saturates
   always_ff @(posedge video_clk or posedge video_reset) begin
      if (video_reset) begin
         frame_q   <= '0;
         sof_err_q <= '0;
      end else if (soft_reset) begin
         frame_q   <= '0;
         sof_err_q <= '0;
      end else begin
         if ((state_q == FLUSH) && pop_last) begin
            frame_q <= frame_q + 32'd1;
         end
         if ((state_q == CAPTURE) && accept && s_axis_tuser && (sof_err_q != '1)) begin
            sof_err_q <= sof_err_q + 16'd1;
         end
      end
   end

   assign frame_count   = frame_q;
   assign sof_err_count = sof_err_q;
`else
   assign frame_count   = '0;
   assign sof_err_count = '0;
`endif

endmodule

// File: tb/tb_frame_packager.sv
// Directed bench for frame_packager: table of frame scenarios plus reset, idle and soft-reset sequences.
module tb_frame_packager;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned LCNT_W = 16;

   logic              video_clk = 1'b0;
   logic              video_reset;
   logic              enable;
   logic              soft_reset;
   logic [LCNT_W-1:0] line_count;
   logic [LCNT_W-1:0] lines_done;
   logic              busy;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic              s_axis_tuser;
   logic              s_axis_tlast;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tlast;
   logic              m_axis_tuser;
   logic [31:0]       frame_count;
   logic [15:0]       sof_err_count;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int lcnt;
      int line_len;
      int lines_sent;
      int pre_beats;
      int rdy_mode;
      int drop_at;
      int sof_err_at;
      int exp_beats;
      int exp_lines;
   } vec_t;

   vec_t vecs[6];

   frame_packager #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (16),
      .LCNT_W     (LCNT_W),
      .CONTINUOUS (1)
   ) dut (
      .video_clk     (video_clk),
      .video_reset   (video_reset),
      .enable        (enable),
      .soft_reset    (soft_reset),
      .line_count    (line_count),
      .lines_done    (lines_done),
      .busy          (busy),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .frame_count   (frame_count),
      .sof_err_count (sof_err_count)
   );

   always #5 video_clk = ~video_clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drives one frame (optional non-SOF beats first) and scoreboards the packet.
   // Frame beat k carries data k*7+3, tuser on k==0 (or sof_err_at), tlast at each line end.
   task automatic run_case(input vec_t v, input int id);
      int   total;
      int   idx;
      int   k;
      int   outk;
      int   budget;
      int   tail;
      bit   tready_seen;
      bit   stalled;
      bit   pre_stall;
      bit   prev_hold;
      logic [DATA_W+1:0] prev_beat;
      logic [DATA_W+1:0] cur;
      logic [DATA_W+1:0] exp_beat;
      line_count    = LCNT_W'(v.lcnt);
      enable        = 1'b1;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) @(negedge video_clk);
      total       = v.pre_beats + v.line_len * v.lines_sent;
      idx         = 0;
      outk        = 0;
      budget      = 0;
      tail        = 0;
      tready_seen = 1'b0;
      stalled     = 1'b0;
      pre_stall   = 1'b0;
      prev_hold   = 1'b0;
      prev_beat   = '0;
      while (tail < 150 && budget < 3000) begin
         @(negedge video_clk);
         budget++;
         cyc++;
         if (s_axis_tvalid && tready_seen) idx++;
         if (idx < total) begin
            s_axis_tvalid = 1'b1;
            if (idx < v.pre_beats) begin
               s_axis_tdata = 8'hEE;
               s_axis_tuser = 1'b0;
               s_axis_tlast = 1'b0;
            end else begin
               k = idx - v.pre_beats;
               s_axis_tdata = DATA_W'(k * 7 + 3);
               s_axis_tuser = (k == 0) || (k == v.sof_err_at);
               s_axis_tlast = ((k % v.line_len) == v.line_len - 1);
               if (k == v.drop_at) enable = 1'b0;
            end
            if (!s_axis_tready) begin
               if (idx < v.pre_beats) pre_stall = 1'b1;
               else if (idx - v.pre_beats < v.exp_beats) stalled = 1'b1;
            end
         end else begin
            s_axis_tvalid = 1'b0;
            tail++;
         end
         tready_seen = s_axis_tready;
         m_axis_tready = (v.rdy_mode == 0) || ((cyc % 3) == 0);
         cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
         if (prev_hold)
            check($sformatf("case%0d hold", id), (m_axis_tvalid && cur == prev_beat) ? 1 : 0, 1);
         if (m_axis_tvalid && m_axis_tready) begin
            exp_beat = {outk == 0, outk == v.exp_beats - 1, DATA_W'(outk * 7 + 3)};
            check($sformatf("case%0d beat%0d", id, outk), cur, exp_beat);
            outk++;
         end
         prev_hold = m_axis_tvalid && !m_axis_tready;
         prev_beat = cur;
      end
      if (budget >= 3000) check($sformatf("case%0d timeout", id), 1, 0);
      check($sformatf("case%0d beat_count", id), outk, v.exp_beats);
      check($sformatf("case%0d lines_done", id), lines_done, v.exp_lines);
      check($sformatf("case%0d fifo_stall", id), stalled, (v.rdy_mode == 1) ? 1 : 0);
      if (v.pre_beats > 0) check($sformatf("case%0d pre_stall", id), pre_stall, 0);
      if (v.drop_at >= 0) check($sformatf("case%0d busy_after_drop", id), busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            lcnt len sent pre rdy drop sof  beats lines
      vecs[0] = '{4, 8, 4, 0, 0, -1, -1, 32, 4};
      vecs[1] = '{4, 8, 4, 0, 1, -1, -1, 32, 4};
      vecs[2] = '{2, 3, 2, 5, 0, -1, -1, 6, 2};
      vecs[3] = '{4, 8, 4, 0, 0, 12, -1, 16, 2};
      vecs[4] = '{0, 5, 2, 0, 0, -1, -1, 5, 1};
      vecs[5] = '{3, 1, 3, 0, 0, -1, -1, 3, 3};

      video_reset   = 1'b1;
      enable        = 1'b0;
      soft_reset    = 1'b0;
      line_count    = LCNT_W'(4);
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) @(negedge video_clk);
      check("rst m_tvalid", m_axis_tvalid, 0);
      check("rst m_tlast", m_axis_tlast, 0);
      check("rst m_tuser", m_axis_tuser, 0);
      check("rst m_tdata", m_axis_tdata, 0);
      check("rst lines_done", lines_done, 0);
      check("rst busy", busy, 0);
      check("rst s_tready", s_axis_tready, 0);
      check("rst frame_count", frame_count, 0);
      check("rst sof_err_count", sof_err_count, 0);
      video_reset = 1'b0;
      @(negedge video_clk);
      check("idle s_tready", s_axis_tready, 1);

      // IDLE drains the source without producing output, even on SOF beats
      for (int i = 0; i < 6; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = DATA_W'(8'h50 + i);
         s_axis_tuser  = i[0];
         s_axis_tlast  = 1'b1;
         @(negedge video_clk);
         check("idle drain s_tready", s_axis_tready, 1);
         check("idle drain m_tvalid", m_axis_tvalid, 0);
      end
      s_axis_tvalid = 1'b0;

      for (int i = 0; i < 6; i++) run_case(vecs[i], i);

      // soft_reset with packet half queued: everything dropped, no tlast later
      enable        = 1'b1;
      line_count    = LCNT_W'(4);
      m_axis_tready = 1'b0;
      repeat (3) @(negedge video_clk);
      for (int i = 0; i < 9; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = DATA_W'(i);
         s_axis_tuser  = (i == 0);
         s_axis_tlast  = ((i % 4) == 3);
         @(negedge video_clk);
      end
      s_axis_tvalid = 1'b0;
      check("pre_sr lines_done", lines_done, 2);
      check("pre_sr busy", busy, 1);
      check("pre_sr m_tvalid", m_axis_tvalid, 1);
      soft_reset = 1'b1;
      @(negedge video_clk);
      soft_reset = 1'b0;
      check("sr m_tvalid", m_axis_tvalid, 0);
      check("sr lines_done", lines_done, 0);
      check("sr busy", busy, 0);
      check("sr s_tready", s_axis_tready, 0);
      m_axis_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge video_clk);
         check("post_sr m_tvalid", m_axis_tvalid, 0);
      end

      // Three packets, one carrying a stray SOF mid-frame
      run_case('{2, 3, 2, 0, 0, -1, -1, 6, 2}, 10);
      run_case('{2, 3, 2, 0, 0, -1, 4, 6, 2}, 11);
      run_case('{2, 3, 2, 0, 0, -1, -1, 6, 2}, 12);
`ifdef PACKAGER_STATS_EN
      check("stats frame_count", frame_count, 3);
      check("stats sof_err_count", sof_err_count, 1);
`else
      check("stats frame_count", frame_count, 0);
      check("stats sof_err_count", sof_err_count, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
